// File: rtl/can_wb_pkg.sv
// can_wb_pkg
//   Register map and field positions of the CAN controller RX window, plus
//   the state encoding of the RX-draining Wishbone initiator.
//   Shared with the CAN slave register file so both sides agree on offsets.
package can_wb_pkg;

   // register offsets inside the CAN slave window
   localparam logic [7:0] STATUS_OFS = 8'h04;
   localparam logic [7:0] ID_OFS     = 8'h10;
   localparam logic [7:0] INFO_OFS   = 8'h14;
   localparam logic [7:0] DATAL_OFS  = 8'h18;
   localparam logic [7:0] DATAH_OFS  = 8'h1C;
   localparam logic [7:0] POP_OFS    = 8'h20;

   // STATUS / ID / INFO field positions
   localparam int EMPTY_BIT    = 1;
   localparam int ID_W         = 29;
   localparam int INFO_DLC_LSB = 0;
   localparam int INFO_RTR_BIT = 4;
   localparam int INFO_EXT_BIT = 5;
   localparam int INFO_FMI_LSB = 6;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_POLL,
      ST_GAP,
      ST_RD_ID,
      ST_RD_INFO,
      ST_RD_DL,
      ST_RD_DH,
      ST_POP,
      ST_PRESENT
   } rx_state_e;

   // absolute bus address of a register in the window
   function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] ofs);
      return base + {24'h0, ofs};
   endfunction

endpackage

// File: rtl/can_wbm_access.sv
// can_wbm_access
//   Single-access Wishbone classic engine. A level request with
//   addr/we/wdata starts one access when the bus is idle; the bus signals are
//   held until ack is sampled, then dropped for at least one cycle.
//   Ports:
//     clk, rst            clock, async active-high reset
//     req, addr, we, wdata  access request from the sequencer
//     done                high in the ack cycle (combinational)
//     rdata               read data, valid while done is high
//     err                 high in the cycle an access is aborted on timeout
//     wbm_*               Wishbone initiator signals
//   Config: WB_TIMEOUT_EN adds a per-access ack timeout of TIMEOUT_CYC cycles.
import can_wb_pkg::*;

module can_wbm_access #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i
);

   assign done  = wbm_cyc_o & wbm_ack_i;
   assign rdata = wbm_dat_i;

`ifdef WB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_cnt;

   // counts cycles of the current access; zero whenever the bus is idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             tmo_cnt <= '0;
      else if (!wbm_cyc_o) tmo_cnt <= '0;
      else                 tmo_cnt <= tmo_cnt + 1'b1;
   end

   // abort at the end of the TIMEOUT_CYC-th cycle without ack
   assign err = wbm_cyc_o & ~wbm_ack_i & (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'h0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else if (wbm_cyc_o) begin
         if (done || err) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
         end
      end else if (req) begin
         // starting only from an idle bus cycle guarantees the gap between accesses
         wbm_cyc_o <= 1'b1;
         wbm_stb_o <= 1'b1;
         wbm_we_o  <= we;
         wbm_sel_o <= 4'hF;
         wbm_adr_o <= addr;
         wbm_dat_o <= wdata;
      end
   end

endmodule

// File: rtl/can_rx_wb_master.sv
// can_rx_wb_master
//   Wishbone classic initiator draining the CAN controller RX FIFO. Polls
//   STATUS; while non-empty reads ID, INFO, DATA_L, DATA_H, writes POP and
//   presents the frame on a valid/ready stream.
//   Ports:
//     wb_clk_i, wb_rst_i   clock, async active-high reset
//     wbm_*                Wishbone initiator (sel is 4'hF during a cycle)
//     enable               run the poll loop
//     frame_valid/ready    frame stream handshake
//     frame_id/dlc/rtr/ext/fmi/data   frame fields, stable while valid
//     frame_count          frames delivered (wraps)
//     bus_err              one-cycle pulse on ack timeout
//   Config: WB_TIMEOUT_EN enables the ack timeout (TIMEOUT_CYC); otherwise
//   accesses wait indefinitely and bus_err stays 0.
import can_wb_pkg::*;

module can_rx_wb_master #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          POLL_GAP  = 16
`ifdef WB_TIMEOUT_EN
   ,parameter int         TIMEOUT_CYC = 255
`endif
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i,
   input  logic        enable,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [28:0] frame_id,
   output logic [3:0]  frame_dlc,
   output logic        frame_rtr,
   output logic        frame_ext,
   output logic [4:0]  frame_fmi,
   output logic [63:0] frame_data,
   output logic [15:0] frame_count,
   output logic        bus_err
);

   rx_state_e   state_q, state_d;
   logic [15:0] gap_cnt;
   logic        acc_req, acc_we, acc_done, acc_err;
   logic [31:0] acc_addr, acc_wdata, acc_rdata;

   can_wbm_access #(
`ifdef WB_TIMEOUT_EN
      .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
   ) u_access (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .req       (acc_req),
      .addr      (acc_addr),
      .we        (acc_we),
      .wdata     (acc_wdata),
      .done      (acc_done),
      .rdata     (acc_rdata),
      .err       (acc_err),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_sel_o (wbm_sel_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_ack_i (wbm_ack_i)
   );

   assign frame_valid = (state_q == ST_PRESENT);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Access states keep req high; the engine only starts from an idle bus,
   // and every completed access moves the FSM on, so no access repeats.
   always_comb begin
      state_d   = state_q;
      acc_req   = 1'b0;
      acc_we    = 1'b0;
      acc_addr  = '0;
      acc_wdata = '0;
      case (state_q)
         ST_IDLE: if (enable) state_d = ST_POLL;
         ST_POLL: begin
            acc_req  = 1'b1;
            acc_addr = reg_addr(BASE_ADDR, STATUS_OFS);
            if (acc_done) state_d = acc_rdata[EMPTY_BIT] ? ST_GAP : ST_RD_ID;
         end
         ST_GAP: begin
            if (!enable)                             state_d = ST_IDLE;
            else if (gap_cnt == 16'(POLL_GAP - 1))   state_d = ST_POLL;
         end
         ST_RD_ID: begin
            acc_req  = 1'b1;
            acc_addr = reg_addr(BASE_ADDR, ID_OFS);
            if (acc_done) state_d = ST_RD_INFO;
         end
         ST_RD_INFO: begin
            acc_req  = 1'b1;
            acc_addr = reg_addr(BASE_ADDR, INFO_OFS);
            if (acc_done) state_d = ST_RD_DL;
         end
         ST_RD_DL: begin
            acc_req  = 1'b1;
            acc_addr = reg_addr(BASE_ADDR, DATAL_OFS);
            if (acc_done) state_d = ST_RD_DH;
         end
         ST_RD_DH: begin
            acc_req  = 1'b1;
            acc_addr = reg_addr(BASE_ADDR, DATAH_OFS);
            if (acc_done) state_d = ST_POP;
         end
         ST_POP: begin
            acc_req   = 1'b1;
            acc_we    = 1'b1;
            acc_addr  = reg_addr(BASE_ADDR, POP_OFS);
            acc_wdata = 32'h1;
            if (acc_done) state_d = ST_PRESENT;
         end
         ST_PRESENT: if (frame_ready) state_d = enable ? ST_POLL : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // a timed-out access abandons the frame; the entry stays in the FIFO
      if (acc_err) state_d = ST_IDLE;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         gap_cnt     <= '0;
         frame_id    <= '0;
         frame_dlc   <= '0;
         frame_rtr   <= 1'b0;
         frame_ext   <= 1'b0;
         frame_fmi   <= '0;
         frame_data  <= '0;
         frame_count <= '0;
         bus_err     <= 1'b0;
      end else begin
         gap_cnt <= (state_q == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
         bus_err <= acc_err;
         if (acc_done) begin
            case (state_q)
               ST_RD_ID:   frame_id <= acc_rdata[ID_W-1:0];
               ST_RD_INFO: begin
                  frame_dlc <= acc_rdata[INFO_DLC_LSB +: 4];
                  frame_rtr <= acc_rdata[INFO_RTR_BIT];
                  frame_ext <= acc_rdata[INFO_EXT_BIT];
                  frame_fmi <= acc_rdata[INFO_FMI_LSB +: 5];
               end
               ST_RD_DL:   frame_data[31:0]  <= acc_rdata;
               ST_RD_DH:   frame_data[63:32] <= acc_rdata;
               default: ;
            endcase
         end
         if (frame_valid && frame_ready) frame_count <= frame_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_can_rx_wb_master.sv
module tb_can_rx_wb_master;

   localparam logic [31:0] A_STATUS = 32'h3000_0004;
   localparam logic [31:0] A_ID     = 32'h3000_0010;
   localparam logic [31:0] A_INFO   = 32'h3000_0014;
   localparam logic [31:0] A_DL     = 32'h3000_0018;
   localparam logic [31:0] A_DH     = 32'h3000_001C;
   localparam logic [31:0] A_POP    = 32'h3000_0020;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;
   logic        enable = 1'b0, frame_ready = 1'b0;
   logic        frame_valid, frame_rtr, frame_ext, bus_err;
   logic [28:0] frame_id;
   logic [3:0]  frame_dlc;
   logic [4:0]  frame_fmi;
   logic [63:0] frame_data;
   logic [15:0] frame_count;

   can_rx_wb_master dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
      .enable(enable), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_id(frame_id), .frame_dlc(frame_dlc), .frame_rtr(frame_rtr),
      .frame_ext(frame_ext), .frame_fmi(frame_fmi), .frame_data(frame_data),
      .frame_count(frame_count), .bus_err(bus_err)
   );

   // ---------------- slave model: zero-wait ack, FIFO of identical entries
   logic [31:0] id_val = 0, info_val = 0, dl_val = 0, dh_val = 0;
   int          avail = 0;
   logic        block_info = 1'b0;

   // monitor state (written only by the monitor)
   int cyc_n = 0, acc_cnt = 0, pop_cnt = 0, stat_cnt = 0, last_stat = 0, prev_stat = 0;
   int hs_cnt = 0, last_hs = 0, prev_hs = 0, valid_hi = 0, berr_cnt = 0, info_wait = 0;
   int proto_err = 0;
   logic prev_ack = 1'b0;
   logic [31:0] addr_log [0:1023];

   assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ~(block_info && wbm_adr_o == A_INFO);

   always_comb begin
      wbm_dat_i = 32'h0;
      case (wbm_adr_o)
         A_STATUS: wbm_dat_i = (pop_cnt >= avail) ? 32'h2 : 32'h0;
         A_ID:     wbm_dat_i = id_val;
         A_INFO:   wbm_dat_i = info_val;
         A_DL:     wbm_dat_i = dl_val;
         A_DH:     wbm_dat_i = dh_val;
         default:  wbm_dat_i = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      if (wbm_cyc_o && wbm_sel_o !== 4'hF) proto_err <= proto_err + 1;
      if (prev_ack && wbm_cyc_o)           proto_err <= proto_err + 1;
      prev_ack <= wbm_cyc_o & wbm_ack_i;
      if (wbm_cyc_o && wbm_ack_i) begin
         acc_cnt <= acc_cnt + 1;
         addr_log[acc_cnt % 1024] <= wbm_adr_o;
         if (wbm_we_o && wbm_adr_o == A_POP && wbm_dat_o == 32'h1) pop_cnt <= pop_cnt + 1;
         if (!wbm_we_o && wbm_adr_o == A_STATUS) begin
            stat_cnt  <= stat_cnt + 1;
            prev_stat <= last_stat;
            last_stat <= cyc_n;
         end
      end
      if (frame_valid && frame_ready) begin
         hs_cnt  <= hs_cnt + 1;
         prev_hs <= last_hs;
         last_hs <= cyc_n;
      end
      if (frame_valid) valid_hi <= valid_hi + 1;
      if (bus_err)     berr_cnt <= berr_cnt + 1;
      if (wbm_cyc_o && wbm_adr_o == A_INFO && !wbm_ack_i) info_wait <= info_wait + 1;
   end

   int checks = 0, errors = 0;

   task automatic load_frame(input logic [31:0] id, info, dl, dh, input int n);
      @(negedge clk);
      id_val = id; info_val = info; dl_val = dl; dh_val = dh;
      avail  = pop_cnt + n;
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (frame_valid) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; frame_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb got %b%b exp 00", wbm_cyc_o, wbm_stb_o); end
      checks++; if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0 || wbm_we_o !== 1'b0) begin errors++; $display("FAIL reset_bus got adr %h dat %h sel %h we %b exp 0", wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o); end
      checks++; if (frame_valid !== 1'b0 || frame_count !== 16'h0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset_stream got v %b cnt %h err %b exp 0", frame_valid, frame_count, bus_err); end
      checks++; if (frame_id !== 29'h0 || frame_data !== 64'h0 || frame_dlc !== 4'h0) begin errors++; $display("FAIL reset_fields got id %h data %h exp 0", frame_id, frame_data); end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (acc_cnt !== 0) begin errors++; $display("FAIL idle_no_access got %0d exp 0", acc_cnt); end
   endtask

   task automatic test_empty();
      int s0, a0, v0;
      s0 = stat_cnt; a0 = acc_cnt; v0 = valid_hi;
      enable = 1'b1;
      repeat (100) @(negedge clk);
      checks++; if (stat_cnt - s0 < 4) begin errors++; $display("FAIL empty_polls got %0d exp >=4", stat_cnt - s0); end
      checks++; if (acc_cnt - a0 !== stat_cnt - s0) begin errors++; $display("FAIL empty_only_status got %0d exp %0d", acc_cnt - a0, stat_cnt - s0); end
      checks++; if (last_stat - prev_stat !== 18) begin errors++; $display("FAIL empty_poll_spacing got %0d exp 18", last_stat - prev_stat); end
      checks++; if (valid_hi !== v0) begin errors++; $display("FAIL empty_no_valid got %0d exp %0d", valid_hi, v0); end
   endtask

   task automatic test_one_frame();
      bit ok; int p0, v0;
      logic [31:0] exp_seq [6];
      exp_seq[0] = A_STATUS; exp_seq[1] = A_ID; exp_seq[2] = A_INFO;
      exp_seq[3] = A_DL; exp_seq[4] = A_DH; exp_seq[5] = A_POP;
      frame_ready = 1'b1;
      p0 = pop_cnt; v0 = valid_hi;
      load_frame(32'h123, 32'h08, 32'hDDCCBBAA, 32'h11223344, 1);
      wait_valid(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL one_valid_timeout got 0 exp 1"); end
      checks++; if (frame_data !== 64'h11223344DDCCBBAA) begin errors++; $display("FAIL one_data got %h exp 11223344ddccbbaa", frame_data); end
      checks++; if (frame_id !== 29'h123 || frame_dlc !== 4'd8 || frame_rtr !== 1'b0 || frame_ext !== 1'b0 || frame_fmi !== 5'd0) begin errors++; $display("FAIL one_fields got id %h dlc %0d rtr %b ext %b fmi %0d exp 123 8 0 0 0", frame_id, frame_dlc, frame_rtr, frame_ext, frame_fmi); end
      checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL one_pop got %0d exp 1", pop_cnt - p0); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (addr_log[(acc_cnt - 6 + k) % 1024] !== exp_seq[k]) begin errors++; $display("FAIL one_seq%0d got %h exp %h", k, addr_log[(acc_cnt - 6 + k) % 1024], exp_seq[k]); end
      end
      @(negedge clk);
      checks++; if (frame_valid !== 1'b0 || frame_count !== 16'd1) begin errors++; $display("FAIL one_handshake got v %b cnt %0d exp 0 1", frame_valid, frame_count); end
      checks++; if (valid_hi - v0 !== 1) begin errors++; $display("FAIL one_valid_width got %0d exp 1", valid_hi - v0); end
   endtask

   task automatic test_ext_rtr();
      bit ok;
      load_frame(32'hFABCDEF0, 32'hFFFFF8F0, 32'h01234567, 32'h89ABCDEF, 1);
      wait_valid(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ext_valid_timeout got 0 exp 1"); end
      checks++; if (frame_id !== 29'h1ABCDEF0) begin errors++; $display("FAIL ext_id got %h exp 1abcdef0", frame_id); end
      checks++; if (frame_ext !== 1'b1 || frame_rtr !== 1'b1 || frame_fmi !== 5'd3 || frame_dlc !== 4'd0) begin errors++; $display("FAIL ext_info got ext %b rtr %b fmi %0d dlc %0d exp 1 1 3 0", frame_ext, frame_rtr, frame_fmi, frame_dlc); end
      checks++; if (frame_data !== 64'h89ABCDEF01234567) begin errors++; $display("FAIL ext_data got %h exp 89abcdef01234567", frame_data); end
      @(negedge clk);
      checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL ext_count got %0d exp 2", frame_count); end
   endtask

   task automatic test_back_to_back();
      int h0, p0; bit ok;
      h0 = hs_cnt; p0 = pop_cnt; ok = 0;
      load_frame(32'h321, 32'h02, 32'h0000BEEF, 32'h0, 2);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (hs_cnt - h0 >= 2) begin ok = 1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d exp 2", hs_cnt - h0); end
      checks++; if (last_hs - prev_hs !== 13) begin errors++; $display("FAIL b2b_throughput got %0d exp 13", last_hs - prev_hs); end
      checks++; if (pop_cnt - p0 !== 2 || frame_count !== 16'd4) begin errors++; $display("FAIL b2b_counts got pops %0d cnt %0d exp 2 4", pop_cnt - p0, frame_count); end
   endtask

   task automatic test_backpressure();
      bit ok; int a0, bad;
      frame_ready = 1'b0; bad = 0;
      load_frame(32'h7FF, 32'h05, 32'hCAFEBABE, 32'h0BADF00D, 1);
      wait_valid(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_valid_timeout got 0 exp 1"); end
      a0 = acc_cnt;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (frame_valid !== 1'b1 || frame_id !== 29'h7FF || frame_dlc !== 4'd5 || frame_data !== 64'h0BADF00DCAFEBABE || wbm_cyc_o !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles exp 0", bad); end
      checks++; if (acc_cnt !== a0 || frame_count !== 16'd4) begin errors++; $display("FAIL bp_hold got acc %0d cnt %0d exp %0d 4", acc_cnt, frame_count, a0); end
      frame_ready = 1'b1;
      @(negedge clk);
      checks++; if (frame_count !== 16'd5 || frame_valid !== 1'b0) begin errors++; $display("FAIL bp_release got cnt %0d v %b exp 5 0", frame_count, frame_valid); end
   endtask

   task automatic test_enable_drop();
      bit ok, hit; int p0, a0, v0;
      p0 = pop_cnt; hit = 0;
      load_frame(32'h055, 32'h3C4, 32'h5555AAAA, 32'hAAAA5555, 1);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wbm_cyc_o && wbm_adr_o == A_DL) begin hit = 1; break; end
      end
      enable = 1'b0;
      checks++; if (!hit) begin errors++; $display("FAIL drop_dl_seen got 0 exp 1"); end
      wait_valid(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_valid_timeout got 0 exp 1"); end
      checks++; if (frame_id !== 29'h055 || frame_dlc !== 4'd4 || frame_fmi !== 5'd15 || frame_data !== 64'hAAAA55555555AAAA) begin errors++; $display("FAIL drop_fields got id %h dlc %0d fmi %0d data %h", frame_id, frame_dlc, frame_fmi, frame_data); end
      @(negedge clk);
      checks++; if (frame_count !== 16'd6 || pop_cnt - p0 !== 1) begin errors++; $display("FAIL drop_count got cnt %0d pops %0d exp 6 1", frame_count, pop_cnt - p0); end
      a0 = acc_cnt; v0 = valid_hi;
      repeat (60) @(negedge clk);
      checks++; if (acc_cnt !== a0 || valid_hi !== v0) begin errors++; $display("FAIL drop_idle got acc %0d valid %0d exp %0d %0d", acc_cnt, valid_hi, a0, v0); end
   endtask

`ifdef WB_TIMEOUT_EN
   task automatic test_timeout();
      bit seen; int b0, p0, v0, w0;
      b0 = berr_cnt; p0 = pop_cnt; v0 = valid_hi; w0 = info_wait; seen = 0;
      block_info = 1'b1; enable = 1'b1; frame_ready = 1'b1;
      load_frame(32'h0AA, 32'h01, 32'h1, 32'h2, 1);
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (bus_err) begin seen = 1; break; end
      end
      enable = 1'b0;
      checks++; if (!seen) begin errors++; $display("FAIL tmo_bus_err_seen got 0 exp 1"); end
      checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_cyc_drop got %b exp 0", wbm_cyc_o); end
      checks++; if (info_wait - w0 !== 255) begin errors++; $display("FAIL tmo_length got %0d exp 255", info_wait - w0); end
      @(negedge clk);
      checks++; if (bus_err !== 1'b0 || berr_cnt - b0 !== 1) begin errors++; $display("FAIL tmo_pulse got err %b cnt %0d exp 0 1", bus_err, berr_cnt - b0); end
      checks++; if (pop_cnt !== p0 || valid_hi !== v0) begin errors++; $display("FAIL tmo_discard got pops %0d valid %0d exp %0d %0d", pop_cnt - p0, valid_hi - v0, 0, 0); end
      block_info = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      bit hit, ok; int p0;
      p0 = pop_cnt; hit = 0;
      block_info = 1'b1; frame_ready = 1'b1;
      load_frame(32'h4D2, 32'h03, 32'h76543210, 32'hFEDCBA98, 1);
      enable = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wbm_cyc_o && wbm_adr_o == A_INFO) begin hit = 1; break; end
      end
      rst = 1'b1;
      #1;
      checks++; if (!hit || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || frame_count !== 16'd0) begin errors++; $display("FAIL mid_reset_async got hit %b cyc %b stb %b cnt %0d exp 1 0 0 0", hit, wbm_cyc_o, wbm_stb_o, frame_count); end
      @(negedge clk);
      block_info = 1'b0; rst = 1'b0;
      wait_valid(300, ok);
      checks++; if (!ok || frame_id !== 29'h4D2 || frame_data !== 64'hFEDCBA9876543210) begin errors++; $display("FAIL mid_reset_reread got ok %b id %h data %h exp 1 4d2 fedcba9876543210", ok, frame_id, frame_data); end
      @(negedge clk);
      checks++; if (frame_count !== 16'd1 || pop_cnt - p0 !== 1) begin errors++; $display("FAIL mid_reset_pop got cnt %0d pops %0d exp 1 1", frame_count, pop_cnt - p0); end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_empty();
      test_one_frame();
      test_ext_rtr();
      test_back_to_back();
      test_backpressure();
      test_enable_drop();
`ifdef WB_TIMEOUT_EN
      test_timeout();
`else
      checks++; if (berr_cnt !== 0) begin errors++; $display("FAIL no_bus_err got %0d exp 0", berr_cnt); end
`endif
      test_reset_mid();
      checks++; if (proto_err !== 0) begin errors++; $display("FAIL wb_protocol got %0d exp 0", proto_err); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
